// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment path. The display bus is
// active-low, so a lit segment is a 0 on the wire. seg[7] is the decimal
// point and seg[6:0] are segments g..a.
//
// Contents:
//   SEG_BLANK      - pattern on seg[6:0] with every segment dark
//   segPattern()   - hex nibble -> active-low g..a pattern (same table as the encoder)
//   isOneHotLow()  - true when exactly one digit enable is driven low
//   scan_state_e   - scan decoder FSM states
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } scan_state_e;

  // Active-low g..a pattern for each hex digit. Any change here must be
  // mirrored in the encoder, because both sides use this table.
  function automatic logic [6:0] segPattern(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h18;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  // A digit is addressed only when exactly one enable is low. All-high means
  // nothing is being driven, and more than one low bit means the scan driver
  // is mid-transition or misbehaving.
  function automatic logic isOneHotLow(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) ||
           (an == 4'b1011) || (an == 4'b0111);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode
// Purely combinational inverse of the segment table. It turns an active-low
// g..a pattern back into the hex nibble it represents. It also flags the
// all-dark pattern as blank and anything outside the table as an error. In
// both of those cases the nibble is 0.
//
// Ports:
//   pattern_i  in  7  active-low segments g..a (decimal point excluded)
//   nibble_o   out 4  recovered hex value
//   blank_o    out 1  all segments off
//   err_o      out 1  pattern is neither a hex digit nor blank
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  // Start by assuming an error unless the pattern is blank. Then search the
  // shared table, and clear the error on a match. The table entries are
  // distinct, so at most one entry can match.
  always_comb begin
    nibble_o = 4'h0;
    blank_o  = (pattern_i == SEG_BLANK);
    err_o    = (pattern_i != SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == segPattern(4'(i))) begin
        nibble_o = 4'(i);
        err_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a multiplexed active-low seven-segment bus and recovers what each
// of the four digits is showing. The segment and enable lines must hold the
// same value for STABLE_CYC consecutive samples before the addressed digit
// slot is written. This rejects ghosting while the scan driver switches
// digits. Each slot write pulses upd. When all four slots have been written,
// frame is pulsed.
//
// Ports:
//   clk      in  1   rising-edge clock
//   rst      in  1   synchronous active-high reset
//   seg      in  8   active-low segments, seg[7]=dp, seg[6:0]=g..a
//   an       in  4   active-low digit enables, an[i]=0 selects digit i
//   digits   out 16  recovered nibbles, digits[4i+3:4i] is digit i
//   dp       out 4   decimal point lit per digit
//   blank    out 4   digit showed all segments off
//   err      out 4   digit showed a non-hex pattern
//   upd      out 1   one-cycle strobe, a slot was written
//   upd_idx  out 2   slot index of the latest write
//   frame    out 1   one-cycle strobe, all four slots written since last frame
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        frame
);

  localparam int              CNT_W   = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       seg_q, segPrev_q;
  logic [3:0]       an_q, anPrev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  scan_state_e      state_q, state_d;

  logic [15:0] digits_q;
  logic [3:0]  dp_q, blank_q, err_q, seen_q;
  logic        upd_q, frame_q;
  logic [1:0]  updIdx_q;

  logic       changed, anOneHot, commit;
  logic [1:0] commitIdx;
  logic [3:0] decNibble;
  logic       decBlank, decErr;
  logic [3:0] seenNext;

  // The input registers also act as the synchronising stage for the external
  // bus. The previous copy lets the FSM compare each sample with the one
  // before it. Reset loads the idle-bus value, so the first real sample is
  // always treated as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
      segPrev_q <= 8'hFF;
      anPrev_q  <= 4'hF;
    end else begin
      seg_q     <= seg;
      an_q      <= an;
      segPrev_q <= seg_q;
      anPrev_q  <= an_q;
    end
  end

  assign changed  = ({seg_q, an_q} != {segPrev_q, anPrev_q});
  assign anOneHot = isOneHotLow(an_q);
  assign cntInc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  seg_pattern_decode uDecode (
    .pattern_i (seg_q[6:0]),
    .nibble_o  (decNibble),
    .blank_o   (decBlank),
    .err_o     (decErr)
  );

  // State register and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter holds the length of the current run of
  // identical samples. A change restarts the run at 1 because the new sample
  // is its first member. Losing a one-hot enable always falls back to WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        if (anOneHot) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      SETTLE: begin
        if (!anOneHot) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = cntInc;
          if (cntInc == CNT_MAX) state_d = HELD;
        end
      end
      HELD: begin
        if (changed) begin
          state_d = anOneHot ? SETTLE : WAIT;
          cnt_d   = anOneHot ? CNT_ONE : '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. A commit fires on the single SETTLE cycle in which the
  // run reaches STABLE_CYC. HELD blocks any repeat write for the same
  // stable period.
  always_comb begin
    commit = (state_q == SETTLE) && anOneHot && !changed && (cntInc == CNT_MAX);
    case (an_q)
      4'b1101: commitIdx = 2'd1;
      4'b1011: commitIdx = 2'd2;
      4'b0111: commitIdx = 2'd3;
      default: commitIdx = 2'd0;
    endcase
    seenNext = seen_q | (4'b0001 << commitIdx);
  end

  // Slot registers, strobes and seen mask. Only the addressed slot changes on
  // a commit. The seen mask clears on the same edge that completes a frame,
  // so the next frame starts counting immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      dp_q     <= '0;
      blank_q  <= 4'b1111;
      err_q    <= '0;
      seen_q   <= '0;
      upd_q    <= 1'b0;
      frame_q  <= 1'b0;
      updIdx_q <= 2'd0;
    end else begin
      upd_q   <= commit;
      frame_q <= commit && (seenNext == 4'b1111);
      if (commit) begin
        digits_q[4*commitIdx +: 4] <= decNibble;
        dp_q[commitIdx]            <= ~seg_q[7];
        blank_q[commitIdx]         <= decBlank;
        err_q[commitIdx]           <= decErr;
        updIdx_q                   <= commitIdx;
        seen_q                     <= (seenNext == 4'b1111) ? 4'b0000 : seenNext;
      end
    end
  end

  assign digits  = digits_q;
  assign dp      = dp_q;
  assign blank   = blank_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = updIdx_q;
  assign frame   = frame_q;

endmodule
